// File: rtl/wr_stream_pkg.sv
// rtl/wr_stream_pkg.sv - state encoding and sizing helpers shared by the write burst buffer
package wr_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        PAD   = 2'd2
    } wr_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // One extra bit so full and empty stay distinguishable on wrapping pointers
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wr_burst_buf_ram.sv
// rtl/wr_burst_buf_ram.sv - circular register buffer with first-word-fall-through head and fill count
module wr_burst_buf_ram
    import wr_stream_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic [WIDTH-1:0]            head_o,
    output logic [ptr_width(DEPTH)-1:0] fill_o
);
    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_i);
            fill_q   <= fill_q + PW'(push_i) - PW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign full_o = (fill_q == PW'(DEPTH));
    assign head_o = mem_q[rd_ptr_q[AW-1:0]];
    assign fill_o = fill_q;

endmodule

// File: rtl/wr_burst_buffer.sv
// rtl/wr_burst_buffer.sv - releases buffered stream data only in whole BURST_LEN bursts
// WR_BURST_PAD_FLUSH_EN adds zero-padded flush bursts for packet tails shorter than a burst.
module wr_burst_buffer
    import wr_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int DEPTH      = 64
) (
    input  logic                        S_WR_aclk,
    input  logic                        S_WR_areset,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [ptr_width(DEPTH)-1:0] fill_level,
    output logic                        busy
);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [7:0]    LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [PW-1:0] BURST_WORDS = PW'(BURST_LEN);

    wr_state_e           state_q;
    logic [7:0]          beat_cnt_q;
    logic                valid_q;
    logic                full;
    logic                push;
    logic                pop;
    logic                handshake;
    logic                start_flush;
    logic                to_pad;
    logic [DATA_WIDTH:0] head;

    assign s_axis_tready = !full && !S_WR_areset;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign handshake     = valid_q && m_axis_tready;
    assign pop           = handshake && (state_q == BURST);

    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = valid_q && (beat_cnt_q == LAST_BEAT);
    assign m_axis_tdata  = (state_q == BURST) ? head[DATA_WIDTH-1:0] : '0;
    assign busy          = (state_q != IDLE);

    wr_burst_buf_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i       (S_WR_aclk),
        .rst_i       (S_WR_areset),
        .push_i      (push),
        .push_data_i ({s_axis_tlast, s_axis_tdata}),
        .pop_i       (pop),
        .full_o      (full),
        .head_o      (head),
        .fill_o      (fill_level)
    );

`ifdef WR_BURST_PAD_FLUSH_EN
    logic [PW-1:0] last_cnt_q;
    logic          flush_q;
    logic          push_last;
    logic          pop_last;

    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop && head[DATA_WIDTH];

    always_ff @(posedge S_WR_aclk) begin
        if (S_WR_areset) begin
            last_cnt_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            last_cnt_q <= last_cnt_q + PW'(push_last) - PW'(pop_last);
            // Latched while idle so the flag describes the burst that is being launched
            if (state_q == IDLE) flush_q <= start_flush;
        end
    end

    assign start_flush = (fill_level != '0) && (fill_level < BURST_WORDS) && (last_cnt_q != '0);
    assign to_pad      = flush_q && pop_last && (beat_cnt_q != LAST_BEAT);
`else
    logic unused_head_last;
    assign unused_head_last = head[DATA_WIDTH];
    assign start_flush      = 1'b0;
    assign to_pad           = 1'b0;
`endif

    always_ff @(posedge S_WR_aclk) begin
        if (S_WR_areset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((fill_level >= BURST_WORDS) || start_flush) begin
                        state_q    <= BURST;
                        valid_q    <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                BURST, PAD: begin
                    if (handshake) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q    <= IDLE;
                            valid_q    <= 1'b0;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            if (to_pad) state_q <= PAD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_burst_buffer.sv
// tb/tb_wr_burst_buffer.sv - randomized self-checking bench for wr_burst_buffer against a burst model
module tb_wr_burst_buffer;
    localparam int DW = 64;
    localparam int BL = 16;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [6:0]    fill;
    logic          busy;

    logic [31:0]   b_s_tdata;
    logic          b_s_tvalid, b_s_tlast, b_s_tready;
    logic [31:0]   b_m_tdata;
    logic          b_m_tvalid, b_m_tlast, b_m_tready;
    logic [1:0]    b_fill;
    logic          b_busy;

    int tests;
    int fails;
    beat_t sent[$];
    beat_t got[$];
    beat_t exp_q[$];
    beat_t b_sent[$];
    beat_t b_got[$];

    always #5 clk = ~clk;

    wr_burst_buffer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .S_WR_aclk(clk), .S_WR_areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .fill_level(fill), .busy(busy)
    );

    wr_burst_buffer #(.DATA_WIDTH(32), .BURST_LEN(1), .DEPTH(2)) dut_b (
        .S_WR_aclk(clk), .S_WR_areset(rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tlast(b_s_tlast), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
        .fill_level(b_fill), .busy(b_busy)
    );

    // Inputs change just after posedge, so the negedge sees what the next posedge will act on
    always @(negedge clk) begin
        if (!rst) begin
            if (s_tvalid && s_tready)     sent.push_back(beat_t'({s_tlast, s_tdata}));
            if (m_tvalid && m_tready)     got.push_back(beat_t'({m_tlast, m_tdata}));
            if (b_s_tvalid && b_s_tready) b_sent.push_back(beat_t'({b_s_tlast, 32'h0, b_s_tdata}));
            if (b_m_tvalid && b_m_tready) b_got.push_back(beat_t'({b_m_tlast, 32'h0, b_m_tdata}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l);
        int t;
        t = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: s_tready stayed 0, required 1");
        end
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Bursts of BL cut from the accepted words; a tlast tail is padded with zeros when flushing is built
    function automatic void build_exp();
        beat_t b;
        int n;
        n = 0;
        exp_q.delete();
        foreach (sent[i]) begin
            n++;
            b.data = sent[i].data;
            b.last = (n == BL);
            exp_q.push_back(b);
            if (n == BL) n = 0;
`ifdef WR_BURST_PAD_FLUSH_EN
            else if (sent[i].last) begin
                while (n < BL) begin
                    n++;
                    b.data = '0;
                    b.last = (n == BL);
                    exp_q.push_back(b);
                end
                n = 0;
            end
`endif
        end
        repeat (n) void'(exp_q.pop_back());
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b required 0", s_tready); end
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset_m_tlast: got %b required 0", m_tlast); end
        tests++; if (m_tdata !== '0) begin fails++; $display("FAIL reset_m_tdata: got %h required 0", m_tdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
        tests++; if (fill !== 7'd0) begin fails++; $display("FAIL reset_fill: got %0d required 0", fill); end
        tests++; if (b_s_tready !== 1'b0) begin fails++; $display("FAIL reset_b_s_tready: got %b required 0", b_s_tready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL release_s_tready: got %b required 1", s_tready); end
        step();
    endtask

    task automatic test_burst_release();
        int t;
        sent.delete(); got.delete();
        m_tready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(DW'(i), 1'b0);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL latency_idle: m_tvalid got %b required 0", m_tvalid); end
        step();
        tests++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h1) begin fails++; $display("FAIL latency_first: tvalid=%b data=%h required 1/1", m_tvalid, m_tdata); end
        build_exp();
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin step(); t++; end
        repeat (4) step();
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL release_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL release_beat%0d: got last=%b data=%h required last=%b data=%h", i, got[i].last, got[i].data, exp_q[i].last, exp_q[i].data); end
        end
        tests++; if (fill !== 7'd0 || busy !== 1'b0) begin fails++; $display("FAIL release_idle: fill=%0d busy=%b required 0/0", fill, busy); end
    endtask

    task automatic test_short_packet();
        int t;
        sent.delete(); got.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) push_word({$urandom, $urandom}, i == 4);
        repeat (40) step();
`ifndef WR_BURST_PAD_FLUSH_EN
        tests++; if (got.size() != 0) begin fails++; $display("FAIL short_no_output: got %0d beats required 0", got.size()); end
        tests++; if (fill !== 7'd5) begin fails++; $display("FAIL short_fill: got %0d required 5", fill); end
        for (int i = 0; i < 11; i++) push_word({$urandom, $urandom}, 1'b0);
`endif
        build_exp();
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin step(); t++; end
        repeat (4) step();
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL short_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL short_beat%0d: got last=%b data=%h required last=%b data=%h", i, got[i].last, got[i].data, exp_q[i].last, exp_q[i].data); end
        end
        tests++; if (fill !== 7'd0 || busy !== 1'b0) begin fails++; $display("FAIL short_idle: fill=%0d busy=%b required 0/0", fill, busy); end
    endtask

    task automatic test_backpressure();
        sent.delete(); got.delete();
        m_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 32; i++) push_word({$urandom, $urandom}, 1'b0);
            end
            begin
                logic [DW-1:0] pd;
                logic          pl;
                logic          stalled;
                int            t;
                stalled = 1'b0;
                t = 0;
                while (got.size() < 32 && t < 600) begin
                    @(negedge clk);
                    if (stalled) begin
                        tests++;
                        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
                            fails++;
                            $display("FAIL stall_hold: got valid=%b data=%h last=%b required 1/%h/%b", m_tvalid, m_tdata, m_tlast, pd, pl);
                        end
                    end
                    stalled = m_tvalid && !m_tready;
                    pd = m_tdata;
                    pl = m_tlast;
                    step();
                    m_tready = ~m_tready;
                    t++;
                end
            end
        join
        m_tready = 1'b1;
        repeat (4) step();
        build_exp();
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat%0d: got last=%b data=%h required last=%b data=%h", i, got[i].last, got[i].data, exp_q[i].last, exp_q[i].data); end
        end
    endtask

    task automatic test_full();
        int t;
        sent.delete(); got.delete();
        m_tready = 1'b0;
        for (int i = 0; i < 64; i++) push_word({$urandom, $urandom}, 1'b0);
        tests++; if (fill !== 7'd64) begin fails++; $display("FAIL full_fill: got %0d required 64", fill); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL full_s_tready: got %b required 0", s_tready); end
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        tests++; if (s_tready !== 1'b1 || fill !== 7'd63) begin fails++; $display("FAIL full_reopen: s_tready=%b fill=%0d required 1/63", s_tready, fill); end
        s_tdata  = {$urandom, $urandom};
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        tests++; if (fill !== 7'd63) begin fails++; $display("FAIL full_push_pop: fill got %0d required 63", fill); end
        m_tready = 1'b1;
        for (int i = 0; i < 15; i++) push_word({$urandom, $urandom}, 1'b0);
        build_exp();
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin step(); t++; end
        repeat (4) step();
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL full_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL full_beat%0d: got last=%b data=%h required last=%b data=%h", i, got[i].last, got[i].data, exp_q[i].last, exp_q[i].data); end
        end
        tests++; if (fill !== 7'd0) begin fails++; $display("FAIL full_drain: fill got %0d required 0", fill); end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        sent.delete(); got.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) push_word({$urandom, $urandom}, 1'b0);
        t = 0;
        while (got.size() < 7 && t < 200) begin step(); t++; end
        rst = 1'b1;
        step();
        tests++; if (m_tvalid !== 1'b0 || fill !== 7'd0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_state: tvalid=%b fill=%0d busy=%b required 0/0/0", m_tvalid, fill, busy); end
        tests++; if (got.size() != 7) begin fails++; $display("FAIL midrst_beats: got %0d beats required 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            tests++;
            if (got[i].data !== sent[i].data || got[i].last !== 1'b0) begin fails++; $display("FAIL midrst_beat%0d: got last=%b data=%h required last=0 data=%h", i, got[i].last, got[i].data, sent[i].data); end
        end
        step();
        rst = 1'b0;
        repeat (5) step();
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_quiet: m_tvalid got %b required 0", m_tvalid); end
        sent.delete(); got.delete();
        for (int i = 0; i < 16; i++) push_word({$urandom, $urandom}, 1'b0);
        build_exp();
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin step(); t++; end
        repeat (4) step();
        tests++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL midrst_after_count: got %0d beats required %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            tests++;
            if (got[i] !== exp_q[i]) begin fails++; $display("FAIL midrst_after_beat%0d: got last=%b data=%h required last=%b data=%h", i, got[i].last, got[i].data, exp_q[i].last, exp_q[i].data); end
        end
    endtask

    task automatic test_bl1();
        b_sent.delete(); b_got.delete();
        b_m_tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    int t;
                    t = 0;
                    b_s_tdata  = $urandom;
                    b_s_tvalid = 1'b1;
                    @(negedge clk);
                    while (!b_s_tready && t < 100) begin @(negedge clk); t++; end
                    step();
                end
                b_s_tvalid = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (b_got.size() < 7 && t < 300) begin
                    step();
                    b_m_tready = 1'($urandom_range(0, 1));
                    t++;
                end
            end
        join
        b_m_tready = 1'b1;
        repeat (4) step();
        tests++; if (b_got.size() != 7 || b_sent.size() != 7) begin fails++; $display("FAIL bl1_count: got %0d beats from %0d words required 7", b_got.size(), b_sent.size()); end
        foreach (b_sent[i]) if (i < b_got.size()) begin
            tests++;
            if (b_got[i].data !== b_sent[i].data || b_got[i].last !== 1'b1) begin fails++; $display("FAIL bl1_beat%0d: got last=%b data=%h required last=1 data=%h", i, b_got[i].last, b_got[i].data, b_sent[i].data); end
        end
        tests++; if (b_fill !== 2'd0 || b_busy !== 1'b0) begin fails++; $display("FAIL bl1_idle: fill=%0d busy=%b required 0/0", b_fill, b_busy); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b0;
        test_reset();
        test_burst_release();
        test_short_packet();
        test_backpressure();
        test_full();
        test_reset_mid_burst();
        test_bl1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
